// File: rtl/axi_ddr3_rd_arbiter_pkg.sv
// Shared constants and helpers for the multi-port AXI read arbiter in front of the
// DDR3 controller.
package axi_ddr3_rd_arbiter_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Port-index width; a single bit is kept even for two ports.
    function automatic int unsigned port_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_ddr3_rd_arbiter_if.sv
// Bundled upstream (s_*) and downstream (m_*) AXI read channels of the arbiter.
// slave: the arbiter's view; master: the surrounding masters plus the controller.
interface axi_ddr3_rd_arbiter_if
    import axi_ddr3_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDRS     = 29,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ID_WIDTH  = 4
) ();
    localparam int unsigned PB = port_bits(NUM_PORTS);

    logic [NUM_PORTS-1:0]          s_arvalid_i;
    logic [NUM_PORTS-1:0]          s_arready_o;
    logic [NUM_PORTS*ADDRS-1:0]    s_araddr_i;
    logic [NUM_PORTS*ID_WIDTH-1:0] s_arid_i;
    logic [NUM_PORTS*8-1:0]        s_arlen_i;
    logic [NUM_PORTS*2-1:0]        s_arburst_i;
    logic [NUM_PORTS-1:0]          s_rvalid_o;
    logic [NUM_PORTS-1:0]          s_rready_i;
    logic [NUM_PORTS-1:0]          s_rlast_o;
    logic [1:0]                    s_rresp_o;
    logic [ID_WIDTH-1:0]           s_rid_o;
    logic [WIDTH-1:0]              s_rdata_o;

    logic                          m_arvalid_o;
    logic                          m_arready_i;
    logic [ADDRS-1:0]              m_araddr_o;
    logic [ID_WIDTH+PB-1:0]        m_arid_o;
    logic [7:0]                    m_arlen_o;
    logic [1:0]                    m_arburst_o;
    logic                          m_rvalid_i;
    logic                          m_rready_o;
    logic                          m_rlast_i;
    logic [1:0]                    m_rresp_i;
    logic [ID_WIDTH+PB-1:0]        m_rid_i;
    logic [WIDTH-1:0]              m_rdata_i;

    logic                          rid_err_o;

    modport slave (
        input  s_arvalid_i, s_araddr_i, s_arid_i, s_arlen_i, s_arburst_i, s_rready_i,
        input  m_arready_i, m_rvalid_i, m_rlast_i, m_rresp_i, m_rid_i, m_rdata_i,
        output s_arready_o, s_rvalid_o, s_rlast_o, s_rresp_o, s_rid_o, s_rdata_o,
        output m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o, m_rready_o,
        output rid_err_o
    );

    modport master (
        output s_arvalid_i, s_araddr_i, s_arid_i, s_arlen_i, s_arburst_i, s_rready_i,
        output m_arready_i, m_rvalid_i, m_rlast_i, m_rresp_i, m_rid_i, m_rdata_i,
        input  s_arready_o, s_rvalid_o, s_rlast_o, s_rresp_o, s_rid_o, s_rdata_o,
        input  m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o, m_rready_o,
        input  rid_err_o
    );

endinterface

// File: rtl/axi_rd_order_fifo.sv
// Issue-order tracking FIFO: holds the port index of every outstanding read burst.
module axi_rd_order_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned AW   = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage carries no reset; entries are only read while the FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/axi_ddr3_rd_arbiter.sv
// Merges NUM_PORTS AXI read masters onto the controller's single read port and routes
// in-order R beats back using the issue-order FIFO.
module axi_ddr3_rd_arbiter
    import axi_ddr3_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDRS     = 29,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned PENDING   = 8,
    parameter int unsigned ARB_MODE  = ARB_RR
) (
    input logic                  clock,
    input logic                  reset_n,
    axi_ddr3_rd_arbiter_if.slave bus
);
    localparam int unsigned PB  = port_bits(NUM_PORTS);
    localparam int unsigned IDW = ID_WIDTH + PB;
    localparam int unsigned CW  = $clog2(PENDING + 1);

    logic                 hold_valid_q;
    logic [ADDRS-1:0]     hold_addr_q;
    logic [IDW-1:0]       hold_id_q;
    logic [7:0]           hold_len_q;
    logic [1:0]           hold_burst_q;
    logic [PB-1:0]        rr_ptr_q;
    logic                 rid_err_q;

    logic                 can_load, grant_valid, accept;
    logic [PB-1:0]        grant_idx;
    logic [ADDRS-1:0]     sel_addr;
    logic [ID_WIDTH-1:0]  sel_id;
    logic [7:0]           sel_len;
    logic [1:0]           sel_burst;
    logic [NUM_PORTS-1:0] arready, rvalid, rlast;
    logic                 rready, r_fire, pop;
    logic [PB-1:0]        fifo_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty, fifo_full;
    int                   idx;

    // Full check uses the registered count, so a same-cycle pop never frees a slot early.
    assign can_load = (~hold_valid_q | bus.m_arready_i) & ~fifo_full;
    assign accept   = can_load & grant_valid;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (ARB_MODE == ARB_FIXED) begin
                idx = i;
            end else begin
                idx = (int'(rr_ptr_q) + i) % int'(NUM_PORTS);
            end
            if (!grant_valid && bus.s_arvalid_i[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PB'(idx);
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_id    = '0;
        sel_len   = '0;
        sel_burst = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (grant_idx == PB'(p)) begin
                sel_addr  = bus.s_araddr_i[p*ADDRS +: ADDRS];
                sel_id    = bus.s_arid_i[p*ID_WIDTH +: ID_WIDTH];
                sel_len   = bus.s_arlen_i[p*8 +: 8];
                sel_burst = bus.s_arburst_i[p*2 +: 2];
            end
        end
    end

    always_comb begin
        arready = '0;
        if (accept) begin
            arready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_id_q    <= '0;
            hold_len_q   <= '0;
            hold_burst_q <= '0;
            rr_ptr_q     <= '0;
        end else if (accept) begin
            hold_valid_q <= 1'b1;
            hold_addr_q  <= sel_addr;
            hold_id_q    <= {grant_idx, sel_id};
            hold_len_q   <= sel_len;
            hold_burst_q <= sel_burst;
            rr_ptr_q     <= (grant_idx == PB'(NUM_PORTS - 1)) ? '0 : grant_idx + PB'(1);
        end else if (bus.m_arready_i) begin
            hold_valid_q <= 1'b0;
        end
    end

    axi_rd_order_fifo #(
        .DEPTH (PENDING),
        .DW    (PB)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (grant_idx),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // With nothing outstanding, rready stays low so a stray beat stalls instead of vanishing.
    always_comb begin
        rvalid = '0;
        rlast  = '0;
        rready = 1'b0;
        if (!fifo_empty) begin
            rvalid[fifo_head] = bus.m_rvalid_i;
            rlast[fifo_head]  = bus.m_rlast_i;
            rready            = bus.s_rready_i[fifo_head];
        end
    end

    assign r_fire = bus.m_rvalid_i & rready;
    assign pop    = r_fire & bus.m_rlast_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rid_err_q <= 1'b0;
        end else if (r_fire && (bus.m_rid_i[IDW-1 -: PB] != fifo_head)) begin
            rid_err_q <= 1'b1;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus.s_arready_o = reset_n ? arready : '0;
    assign bus.s_rvalid_o  = rvalid;
    assign bus.s_rlast_o   = rlast;
    assign bus.m_rready_o  = rready;
    assign bus.s_rresp_o   = reset_n ? bus.m_rresp_i : 2'b00;
    assign bus.s_rid_o     = reset_n ? bus.m_rid_i[ID_WIDTH-1:0] : '0;
    assign bus.s_rdata_o   = reset_n ? bus.m_rdata_i : {WIDTH{1'b0}};
    assign bus.m_arvalid_o = hold_valid_q;
    assign bus.m_araddr_o  = hold_addr_q;
    assign bus.m_arid_o    = hold_id_q;
    assign bus.m_arlen_o   = hold_len_q;
    assign bus.m_arburst_o = hold_burst_q;
    assign bus.rid_err_o   = rid_err_q;

endmodule

// File: doc/axi_ddr3_rd_arbiter.md
Name: axi_ddr3_rd_arbiter

Overview:
- N-port AXI4 read-channel arbiter that merges NUM_PORTS read masters onto the single AXI read port of the DDR3 controller top level.
- Arbitrates the AR channels with a selectable round-robin or fixed-priority policy, and tags each downstream ARID with the port index.
- Records the issue order in a tracking FIFO, then routes the in-order R beats back to the originating port.

Parameters:
- NUM_PORTS, 4, number of upstream read masters (2..8)
- ADDRS, 29, AXI byte-address width
- WIDTH, 32, read-data width
- ID_WIDTH, 4, upstream ARID/RID width; downstream ID width is ID_WIDTH+$clog2(NUM_PORTS)
- PENDING, 8, tracking-FIFO depth (max outstanding bursts, power of 2)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)

Ports:
- clock  in  1  system clock; every register samples on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_arvalid_i  in  NUM_PORTS  per-port AR valid
- s_arready_o  out  NUM_PORTS  per-port AR ready
- s_araddr_i  in  NUM_PORTS*ADDRS  packed addresses; port p in slice [p*ADDRS +: ADDRS]
- s_arid_i  in  NUM_PORTS*ID_WIDTH  packed IDs
- s_arlen_i  in  NUM_PORTS*8  packed burst lengths
- s_arburst_i  in  NUM_PORTS*2  packed burst types
- s_rvalid_o  out  NUM_PORTS  per-port R valid
- s_rready_i  in  NUM_PORTS  per-port R ready
- s_rlast_o  out  NUM_PORTS  per-port R last
- s_rresp_o  out  2  shared R response; qualified by s_rvalid_o
- s_rid_o  out  ID_WIDTH  shared RID with the port prefix stripped
- s_rdata_o  out  WIDTH  shared read data
- m_arvalid_o  out  1  downstream AR valid
- m_arready_i  in  1  downstream AR ready
- m_araddr_o  out  ADDRS  downstream address
- m_arid_o  out  ID_WIDTH+PB  downstream ID = {port, s_arid}, where PB=$clog2(NUM_PORTS)
- m_arlen_o  out  8  downstream burst length
- m_arburst_o  out  2  downstream burst type
- m_rvalid_i  in  1  downstream R valid
- m_rready_o  out  1  downstream R ready
- m_rlast_i  in  1  downstream R last
- m_rresp_i  in  2  downstream R response
- m_rid_i  in  ID_WIDTH+PB  downstream RID
- m_rdata_i  in  WIDTH  downstream read data
- rid_err_o  out  1  sticky flag: returned RID port prefix did not match the FIFO head

Behaviour:
- Reset, asynchronous on reset_n low:
  - all outputs 0, the AR holding register empty, FIFO pointers and count 0, round-robin pointer on port 0, rid_err_o 0.
  - Reset mid-burst discards all in-flight tracking. The downstream controller must be reset in the same cycle.
- AR holding register:
  - One entry, "hold". m_ar* outputs are driven directly from hold.
  - can_load = (~hold_valid | m_arready_i) & (count < PENDING).
- Arbitration, combinational:
  - Evaluated over s_arvalid_i whenever can_load is true.
  - The winner g gets s_arready_o[g]=1 in that cycle; all other ports get 0. At most one ready bit is ever high.
  - Round-robin: search starts at rr_ptr. After each grant, rr_ptr <= g+1, wrapping at NUM_PORTS.
  - Fixed priority: lowest set index wins.
- Accept: s_arvalid[g] & s_arready[g].
  - hold loads {addr, {g, id}, len, burst} and m_arvalid_o is 1 in the next cycle (latency 1).
  - g is pushed into the tracking FIFO in the same cycle.
- Throughput: one AR per cycle while m_arready_i=1 and the FIFO is not full. A downstream handshake and a new load in the same cycle are both legal.
- FIFO full (count==PENDING): all s_arready_o = 0.
  - A pop in the same cycle does not bypass the full check. Grants resume the next cycle.
- FIFO push and pop in the same cycle: count unchanged, both pointers advance, pointers wrap modulo PENDING.
- R routing, combinational, zero latency:
  - h = FIFO head. When the FIFO is non-empty: s_rvalid_o[h] = m_rvalid_i and m_rready_o = s_rready_i[h].
  - The other ports' s_rvalid_o are 0.
  - s_rlast_o[h] = m_rlast_i, and s_rlast_o is 0 on the other ports.
  - s_rdata_o, s_rresp_o and s_rid_o (= m_rid_i[ID_WIDTH-1:0]) are shared by all ports.
- FIFO empty: m_rready_o = 0 and all s_rvalid_o = 0, so any unexpected beat stalls.
- Pop: m_rvalid_i & m_rready_o & m_rlast_i.
- RID check: on every accepted R beat, if m_rid_i[top PB bits] != h, set rid_err_o. It stays set until reset. Data is still routed by h.
- Widths: count is $clog2(PENDING+1) bits. The FIFO stores PB-bit entries. PB=1 is the minimum, also for NUM_PORTS=2.

Decomposition:
- Shared package holds:
  - ARB_RR / ARB_FIXED constants
  - the function for the port-index width (clog2, minimum 1)
  - the AXI burst-type constants already used by the controller
- One sub-module: axi_rd_order_fifo, a PENDING-deep, PB-wide synchronous FIFO with push, pop, head, count, empty and full.
- Arbiter and routing logic stay in the top module.

Test Plan:
- Single AR on port 2 (id=3, len=3, addr=0x100):
  - m_arvalid_o rises 1 cycle after the handshake with m_arid_o={2,3}.
  - 4 R beats route only to port 2 with s_rid_o=3; s_rlast_o[2] is on the 4th beat.
- All 4 ports hold arvalid continuously in round-robin mode with m_arready_i=1:
  - grants occur in the order 0,1,2,3,0.
  - With ARB_MODE=1 port 0 wins every cycle.
- m_arready_i=0 and 9 requests offered with PENDING=8:
  - first grant loads hold, no further grant while hold is stalled.
  - after 8 accepts with no R returned, all s_arready_o stay 0 until the first rlast pop.
- Interleaved ports 1 then 3, each len=1:
  - beats 1-2 reach port 1 and beats 3-4 reach port 3.
  - s_rready_i[3]=0 during beats 1-2 does not block port 1.
- Return m_rid_i prefix=0 while the head is 1:
  - rid_err_o rises the cycle after the beat and stays high; data still goes to port 1.
  - An R beat with the FIFO empty leaves m_rready_o=0.
- Assert reset_n low mid-burst:
  - all outputs go to 0 immediately, with no clock edge needed.
  - after release, count is 0 and the next grant goes to port 0.
